// File: rtl/rs_pulse_gen.sv
// ---------------------------------------------------------------------------
// rs_pulse_gen
//
// Purpose:
//   On each accepted start request, emits a train of N one-cycle pulses.
//   Consecutive pulses are separated by G low cycles, so the pulse period is
//   G+1. When the last pulse ends, the block raises a one-cycle done strobe.
//   An abort cancels the current train at once. A synchronous reset also
//   cancels it, with no completion strobe.
//
// Parameters:
//   DATA_WIDTH - width of the pulse-count field (cnt_i) and of rem_o
//   GAP_WIDTH  - width of the inter-pulse gap field (gap_i)
//
// Ports:
//   clk_i          in   clock, all state changes on the rising edge
//   rst_i          in   synchronous active-high reset
//   start_valid_i  in   start request valid
//   start_ready_o  out  block can accept a request this cycle
//   cnt_i          in   number of pulses N, sampled on handshake
//   gap_i          in   low cycles G between pulses, sampled on handshake
//   abort_i        in   cancel the current train
//   pulse_o        out  generated pulse, high for one cycle per pulse
//   busy_o         out  train in progress
//   rem_o          out  pulses not yet started (current pulse included)
//   done_o         out  one-cycle train-complete strobe
//   irq_clr_i      in   clears irq_o
//   irq_o          out  sticky completion flag
//
// Configuration:
//   RS_PULSE_GEN_IRQ_EN - when this macro is defined, irq_o is a sticky
//   flag. It is set by done_o and cleared by irq_clr_i. A set wins over a
//   clear in the same cycle. When the macro is not defined, irq_o is tied
//   low and irq_clr_i is ignored.
// ---------------------------------------------------------------------------
module rs_pulse_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic [DATA_WIDTH-1:0] cnt_i,
  input  logic [GAP_WIDTH-1:0]  gap_i,
  input  logic                  abort_i,
  output logic                  pulse_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  done_o,
  input  logic                  irq_clr_i,
  output logic                  irq_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [GAP_WIDTH-1:0]  gap_len_q, gap_len_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic                  done_q, done_d;
  logic                  handshake;

  // The reset term keeps ready, pulse and busy low during the reset cycle.
  // Without it, a train in flight would still show up on the outputs until
  // the reset edge clears the state.
  assign start_ready_o = (state_q == IDLE) & ~abort_i & ~rst_i;
  assign handshake     = start_valid_i & start_ready_o;
  assign pulse_o       = (state_q == PULSE) & ~rst_i;
  assign busy_o        = (state_q != IDLE) & ~rst_i;
  assign rem_o         = rem_q;
  assign done_o        = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  // Abort is checked before the state case. This gives it priority over a
  // completion in the same cycle, so no done strobe follows an abort.
  // rem counts down at the end of each pulse cycle. The last pulse is the
  // one that starts with rem == 1. The "<= 1" test also covers rem == 0,
  // so rem can never wrap below zero.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;

    if (abort_i) begin
      state_d   = IDLE;
      rem_d     = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            rem_d     = cnt_i;
            gap_len_d = gap_i;
            if (cnt_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = PULSE;
            end
          end
        end

        PULSE: begin
          if (rem_q <= DATA_WIDTH'(1)) begin
            rem_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - DATA_WIDTH'(1);
            if (gap_len_q == '0) begin
              state_d = PULSE;
            end else begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q;
            end
          end
        end

        // gap_cnt is loaded with G on entry. The GAP state therefore lasts
        // exactly G cycles. It leaves when the count is on its final cycle.
        GAP: begin
          if (gap_cnt_q <= GAP_WIDTH'(1)) begin
            gap_cnt_d = '0;
            state_d   = PULSE;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
          end
        end

        default: begin
          state_d   = IDLE;
          rem_d     = '0;
          gap_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef RS_PULSE_GEN_IRQ_EN
  logic irq_q;

  // The flag is set from the registered done strobe. A clear that arrives
  // in the same cycle as done_o is therefore overridden by the set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else if (done_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_rs_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_rs_pulse_gen
//
// Purpose:
//   Self-checking bench for rs_pulse_gen. A schedule-based reference model
//   works out, for each cycle, where the train is. It uses the handshake
//   cycle, N and G with plain arithmetic. A compare process checks every
//   DUT output against this model on each falling edge. Directed scenarios
//   also pin both the DUT and the model to hand-computed literal values.
//   A randomized phase follows the directed scenarios.
// ---------------------------------------------------------------------------
module tb_rs_pulse_gen;

  localparam int DW = 8;
  localparam int GW = 8;

`ifdef RS_PULSE_GEN_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic          clk_i         = 1'b0;
  logic          rst_i         = 1'b1;
  logic          start_valid_i = 1'b0;
  logic [DW-1:0] cnt_i         = '0;
  logic [GW-1:0] gap_i         = '0;
  logic          abort_i       = 1'b0;
  logic          irq_clr_i     = 1'b0;
  logic          start_ready_o;
  logic          pulse_o;
  logic          busy_o;
  logic [DW-1:0] rem_o;
  logic          done_o;
  logic          irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the train is described by its first pulse cycle, N and G.
  // The pending done strobe is held as an absolute cycle number.
  int mcyc      = 0;
  int m_active  = 0;
  int m_start   = 0;
  int m_n       = 0;
  int m_g       = 0;
  int m_done_at = -1;
  int m_irq     = 0;

  rs_pulse_gen #(
    .DATA_WIDTH(DW),
    .GAP_WIDTH (GW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_valid_i(start_valid_i),
    .start_ready_o(start_ready_o),
    .cnt_i        (cnt_i),
    .gap_i        (gap_i),
    .abort_i      (abort_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .rem_o        (rem_o),
    .done_o       (done_o),
    .irq_clr_i    (irq_clr_i),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for cycle mcyc, derived from the train schedule.
  function automatic void modelOut(output int e_ready, output int e_pulse, output int e_busy,
                                   output int e_rem, output int e_done, output int e_irq);
    int period;
    int span;
    int off;
    int in_train;
    period   = m_g + 1;
    span     = (m_n - 1) * period;
    off      = mcyc - m_start;
    in_train = (m_active != 0 && mcyc >= m_start && mcyc <= m_start + span) ? 1 : 0;
    e_busy   = (in_train != 0 && !rst_i) ? 1 : 0;
    e_pulse  = (in_train != 0 && (off % period) == 0 && !rst_i) ? 1 : 0;
    e_rem    = (in_train != 0) ? m_n - (off + m_g) / period : 0;
    e_done   = (mcyc == m_done_at) ? 1 : 0;
    e_ready  = (in_train == 0 && !abort_i && !rst_i) ? 1 : 0;
    e_irq    = (IRQ_ON != 0) ? m_irq : 0;
  endfunction

  function automatic void modelStep(input int ready_now, input int done_now);
    if (rst_i) begin
      m_active  = 0;
      m_done_at = -1;
      m_irq     = 0;
    end else begin
      m_irq = (done_now != 0 || (m_irq != 0 && !irq_clr_i)) ? 1 : 0;
      if (abort_i) begin
        m_active  = 0;
        m_done_at = -1;
      end else if (start_valid_i && ready_now != 0) begin
        if (cnt_i == '0) begin
          m_active  = 0;
          m_done_at = mcyc + 1;
        end else begin
          m_active  = 1;
          m_start   = mcyc + 1;
          m_n       = int'(cnt_i);
          m_g       = int'(gap_i);
          m_done_at = mcyc + 2 + (m_n - 1) * (m_g + 1);
        end
      end
    end
    mcyc++;
  endfunction

  // Every-cycle comparison against the model, away from the rising edge.
  initial begin
    int er, ep, eb, erem, ed, ei;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      modelOut(er, ep, eb, erem, ed, ei);
      checkOutput("model_ready", 32'(start_ready_o), 32'(er));
      checkOutput("model_pulse", 32'(pulse_o), 32'(ep));
      checkOutput("model_busy", 32'(busy_o), 32'(eb));
      checkOutput("model_rem", 32'(rem_o), 32'(erem));
      checkOutput("model_done", 32'(done_o), 32'(ed));
      checkOutput("model_irq", 32'(irq_o), 32'(ei));
      modelStep(er, ed);
    end
  end

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int v, input int n, input int g, input int ab,
                               input int clr, input int rs);
    start_valid_i = (v != 0);
    cnt_i         = DW'(n);
    gap_i         = GW'(g);
    abort_i       = (ab != 0);
    irq_clr_i     = (clr != 0);
    rst_i         = (rs != 0);
  endtask

  // Pins both the DUT and the model to hand-computed values for this cycle.
  task automatic checkLits(input string tag, input int p, input int b, input int r,
                           input int d, input int rd, input int iq);
    int er, ep, eb, erem, ed, ei;
    #1;
    modelOut(er, ep, eb, erem, ed, ei);
    checkOutput({tag, "_pulse"}, 32'(pulse_o), 32'(p));
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'(b));
    checkOutput({tag, "_rem"}, 32'(rem_o), 32'(r));
    checkOutput({tag, "_done"}, 32'(done_o), 32'(d));
    checkOutput({tag, "_ready"}, 32'(start_ready_o), 32'(rd));
    checkOutput({tag, "_irq"}, 32'(irq_o), 32'(iq));
    checkOutput({tag, "_mpulse"}, 32'(ep), 32'(p));
    checkOutput({tag, "_mrem"}, 32'(erem), 32'(r));
    checkOutput({tag, "_mdone"}, 32'(ed), 32'(d));
    checkOutput({tag, "_mready"}, 32'(er), 32'(rd));
  endtask

  initial begin
    int pA[8]  = '{1, 0, 0, 1, 0, 0, 1, 0};
    int bA[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
    int rA[8]  = '{3, 2, 2, 2, 1, 1, 1, 0};
    int pB[5]  = '{1, 1, 1, 1, 0};
    int rB[5]  = '{4, 3, 2, 1, 0};
    int pD[6]  = '{1, 0, 0, 0, 1, 0};
    int rD[6]  = '{5, 4, 4, 4, 4, 3};
    int pE[7]  = '{1, 0, 1, 0, 1, 1, 0};
    int bE[7]  = '{1, 1, 1, 0, 1, 1, 0};
    int rE[7]  = '{2, 1, 1, 0, 2, 1, 0};
    int dE[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int iE[7]  = '{0, 0, 0, 0, 1, 1, 1};

    $display("[TB] rs_pulse_gen bench starting (irq feature %0d)", IRQ_ON);

    // Reset state and release
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (3) nextCycle();
    checkLits("reset", 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("release", 0, 0, 0, 0, 1, 0);
    repeat (3) nextCycle();

    // N=3, G=2; irq clear coincident with done, then one cycle later
    applyStimulus(1, 3, 2, 0, 0, 0);
    checkLits("a_hs", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      applyStimulus(0, 7, 7, 0, (k == 7) ? 1 : 0, 0);
      checkLits($sformatf("a%0d", k + 1), pA[k], bA[k], rA[k], (k == 7) ? 1 : 0,
                (k == 7) ? 1 : 0, 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkLits("a_irqset", 0, 0, 0, 0, 1, IRQ_ON);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("a_irqclr", 0, 0, 0, 0, 1, 0);

    // N=4, G=0: back-to-back pulses
    nextCycle();
    applyStimulus(1, 4, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkLits($sformatf("b%0d", k + 1), pB[k], (k < 4) ? 1 : 0, rB[k], (k == 4) ? 1 : 0,
                (k == 4) ? 1 : 0, 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkLits("b_irq", 0, 0, 0, 0, 1, IRQ_ON);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("b_irqclr", 0, 0, 0, 0, 1, 0);

    // N=0: immediate done, no pulse, ready stays high
    nextCycle();
    applyStimulus(1, 0, 3, 0, 0, 0);
    checkLits("c_hs", 0, 0, 0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("c1", 0, 0, 0, 1, 1, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkLits("c2", 0, 0, 0, 0, 1, IRQ_ON);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("c3", 0, 0, 0, 0, 1, 0);

    // N=5, G=3: abort in the first gap cycle after the second pulse
    nextCycle();
    applyStimulus(1, 5, 3, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      applyStimulus(0, 0, 0, (k == 5) ? 1 : 0, 0, 0);
      checkLits($sformatf("d%0d", k + 1), pD[k], 1, rD[k], 0, 0, 0);
    end
    for (int k = 7; k <= 20; k++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkLits($sformatf("d%0d", k), 0, 0, 0, 0, 1, 0);
    end

    // Start held during a busy train: the second train follows one idle cycle
    nextCycle();
    applyStimulus(1, 2, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      nextCycle();
      applyStimulus((k < 4) ? 1 : 0, 2, 0, 0, 0, 0);
      checkLits($sformatf("e%0d", k + 1), pE[k], bE[k], rE[k], dE[k],
                (k == 3 || k == 6) ? 1 : 0, IRQ_ON * iE[k]);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkLits("e8", 0, 0, 0, 0, 1, IRQ_ON);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("e9", 0, 0, 0, 0, 1, 0);

    // Reset mid-train: outputs gated in the reset cycle, train abandoned
    nextCycle();
    applyStimulus(1, 3, 1, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkLits("f1", 1, 1, 3, 0, 0, 0);
    nextCycle();
    checkLits("f2", 0, 1, 2, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkLits("f3", 0, 0, 2, 0, 0, 0);
    for (int k = 4; k <= 9; k++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkLits($sformatf("f%0d", k), 0, 0, 0, 0, 1, 0);
    end

    // Randomized traffic checked by the model process
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus(($urandom_range(0, 1) == 1) ? 1 : 0,
                    int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 4)),
                    ($urandom_range(0, 29) == 0) ? 1 : 0,
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    ($urandom_range(0, 149) == 0) ? 1 : 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (40) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_pulse_gen.md
RS_PULSE_GEN -- requirements
Module: rs_pulse_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of pulse-count field and rem_o.
REQ-002 SHALL have parameter GAP_WIDTH, default 8: width of inter-pulse gap field.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port start_valid_i  input  1  request valid.
REQ-007 SHALL have port start_ready_o  output  1  block accepts request.
REQ-008 SHALL have port cnt_i  input  DATA_WIDTH  number of pulses N, sampled on handshake.
REQ-009 SHALL have port gap_i  input  GAP_WIDTH  low cycles G between pulses, sampled on handshake.
REQ-010 SHALL have port abort_i  input  1  cancel current train.
REQ-011 SHALL have port pulse_o  output  1  generated pulse, one cycle high per pulse.
REQ-012 SHALL have port busy_o  output  1  train in progress.
REQ-013 SHALL have port rem_o  output  DATA_WIDTH  pulses not yet started.
REQ-014 SHALL have port done_o  output  1  one-cycle train-complete strobe.
REQ-015 SHALL have port irq_clr_i  input  1  clears irq_o.
REQ-016 SHALL have port irq_o  output  1  sticky completion flag.

Function
REQ-017 SHALL implement FSM states IDLE, PULSE, GAP; busy_o = (state != IDLE); pulse_o = (state == PULSE).
REQ-018 SHALL drive start_ready_o = (state == IDLE) & ~abort_i; handshake = start_valid_i & start_ready_o.
REQ-019 SHALL, on handshake with N>0 in cycle T: latch N into rem, latch G, enter PULSE at T+1.
REQ-020 SHALL, on handshake with N=0: stay IDLE, emit no pulse, assert done_o at T+1.
REQ-021 SHALL decrement rem by 1 at the end of every PULSE cycle; rem_o shows N during the first pulse and 0 after the last pulse.
REQ-022 SHALL, leaving PULSE with rem>1: re-enter PULSE if G=0, else enter GAP for exactly G cycles, then PULSE; pulse period = G+1.
REQ-023 SHALL, leaving PULSE with rem=1: enter IDLE and assert done_o for exactly one cycle, the cycle after the last pulse (T+2+(N-1)(G+1)).
REQ-024 SHALL ignore start_valid_i while busy; cnt_i/gap_i changes mid-train have no effect.
REQ-025 SHALL, on abort_i in any state: next cycle IDLE, rem=0, pulse_o=0, no done_o, no irq set; abort has priority over completion in the same cycle.
REQ-026 SHALL use only DATA_WIDTH/GAP_WIDTH-wide counters; no wrap-around (rem never decrements below 0, gap count reloads from latched G).

Reset
REQ-027 SHALL, while rst_i high at a clock edge: state=IDLE, rem=0, gap counter=0, done_o=0, irq_o=0.
REQ-028 SHALL hold start_ready_o, pulse_o and busy_o at 0 in the cycle rst_i is sampled high, and assert start_ready_o=1 in the first cycle after reset release.
REQ-029 SHALL abandon a train on mid-operation reset with no done_o and no pulse afterwards.

Configuration
REQ-030 SHALL, with RS_PULSE_GEN_IRQ_EN defined: set irq_o on the cycle done_o asserts, clear on irq_clr_i; set wins over a simultaneous clear.
REQ-031 SHALL, without RS_PULSE_GEN_IRQ_EN: keep both ports, tie irq_o to 0 and ignore irq_clr_i; all other behaviour is identical.

Verification
REQ-032 SHALL cover: N=3, G=2, handshake at cycle 10 -> pulse_o at 11, 14, 17; busy_o 11..17; done_o at 18; rem_o 3,2,1 during pulses, then 0.
REQ-033 SHALL cover: N=4, G=0 at cycle 10 -> pulse_o high 11..14 continuously; done_o at 15.
REQ-034 SHALL cover: N=0 at cycle 10 -> no pulse; done_o at 11; start_ready_o stays 1.
REQ-035 SHALL cover: N=5, G=3, abort_i in the first GAP cycle after the 2nd pulse -> next cycle IDLE, rem_o=0, no further pulse, no done_o, start_ready_o=1.
REQ-036 SHALL cover: start_valid_i held high with new N=2 during a busy train -> ignored until IDLE, then accepted; the two trains are separated by one idle cycle.
REQ-037 SHALL cover: macro on, irq_clr_i coincident with done_o -> irq_o=1; irq_clr_i one cycle later -> irq_o=0; rst_i mid-train -> all outputs 0 next cycle.
